// File: rtl/add_stream_pipe_pkg.sv
// add_stream_pipe_pkg
// Constants shared by the generated stream arithmetic operators:
//   overflow-mode encodings, stage-record field widths and the stage
//   advance helper.
package add_stream_pipe_pkg;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SSAT = 1;
  localparam int unsigned MODE_USAT = 2;

  // Stage record is {valid, e, d}; d width is the operator's WIDTH.
  localparam int unsigned STG_V_W = 1;
  localparam int unsigned STG_E_W = 1;

  // A stage may take new contents when it is empty or its successor moves.
  function automatic logic stage_adv(input logic v_q, input logic adv_next);
    return !v_q || adv_next;
  endfunction

endpackage

// File: rtl/add_stream_pipe_stage.sv
// add_stream_stage
// One valid-tagged pipeline register holding a {valid, e, d} token.
//   clk, rst_n   : clock, async active-low reset (clears the whole record)
//   adv          : stage advances this cycle (loads in_* into the record)
//   in_v/e/d     : incoming token from the previous stage or the adder
//   out_v/e/d    : held token
module add_stream_stage #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             adv,
  input  logic             in_v,
  input  logic             in_e,
  input  logic [WIDTH-1:0] in_d,
  output logic             out_v,
  output logic             out_e,
  output logic [WIDTH-1:0] out_d
);

  logic             v_q, v_d;
  logic             e_q, e_d;
  logic [WIDTH-1:0] d_q, d_d;

  // Payload only loads with a real token, so a bubble leaves the old data.
  always_comb begin
    v_d = v_q;
    e_d = e_q;
    d_d = d_q;
    if (adv) begin
      v_d = in_v;
      if (in_v) begin
        e_d = in_e;
        d_d = in_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      e_q <= 1'b0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      e_q <= e_d;
      d_q <= d_d;
    end
  end

  assign out_v = v_q;
  assign out_e = e_q;
  assign out_d = d_q;

endmodule

// File: rtl/add_stream_pipe.sv
// add_stream_pipe
// Flow-controlled pipelined adder: pairs the head tokens of streams a and b
// and emits one sum token per pair on stream s. EOS pairs emit one s_e
// token with zero data; an EOS/data mismatch consumes both heads, emits
// nothing and sets the sticky err flag.
//   WIDTH  : data width (1..64)
//   STAGES : register stages from accept to output (1..4)
//   MODE   : 0 wrap, 1 signed saturate, 2 unsigned saturate
//   clk, rst_n          : clock, async active-low reset
//   a_d/a_e/a_v, a_b    : operand a stream, a_b = 1 when head not taken
//   b_d/b_e/b_v, b_b    : operand b stream, same meaning
//   s_d/s_e/s_v, s_b    : result stream, s_b = 1 holds the output
//   err                 : sticky EOS-mismatch flag
module add_stream_pipe
  import add_stream_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2,
  parameter int unsigned MODE   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_d,
  input  logic             a_e,
  input  logic             a_v,
  output logic             a_b,
  input  logic [WIDTH-1:0] b_d,
  input  logic             b_e,
  input  logic             b_v,
  output logic             b_b,
  output logic [WIDTH-1:0] s_d,
  output logic             s_e,
  output logic             s_v,
  input  logic             s_b,
  output logic             err
);

  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] stg_e;
  logic [STAGES-1:0] stg_adv;
  logic [WIDTH-1:0]  stg_d [STAGES];

  logic             fire;
  logic             mismatch;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] res;
  logic             head_v;
  logic             head_e;
  logic [WIDTH-1:0] head_d;
  logic             err_q, err_d;

  // Advance chain walks back from the output in one block so each stage's
  // enable is a plain function of the valids behind it and s_b.
  always_comb begin
    logic nxt;
    stg_adv = '0;
    nxt     = !s_b;
    for (int unsigned k = 0; k < STAGES; k++) begin
      nxt                    = stage_adv(stg_v[STAGES-1-k], nxt);
      stg_adv[STAGES-1-k]    = nxt;
    end
  end

  // rst_n gates fire so the heads read as not taken while reset is held.
  assign fire     = rst_n && a_v && b_v && stg_adv[0];
  assign a_b      = !fire;
  assign b_b      = !fire;
  assign mismatch = a_e ^ b_e;
  assign sum_ext  = {1'b0, a_d} + {1'b0, b_d};

  always_comb begin
    res = sum_ext[WIDTH-1:0];
    case (MODE)
      MODE_SSAT: begin
        if ((a_d[WIDTH-1] == b_d[WIDTH-1]) && (sum_ext[WIDTH-1] != a_d[WIDTH-1])) begin
          if (a_d[WIDTH-1]) begin
            res            = '0;
            res[WIDTH-1]   = 1'b1;
          end else begin
            res            = '1;
            res[WIDTH-1]   = 1'b0;
          end
        end
      end
      MODE_USAT: begin
        if (sum_ext[WIDTH]) res = '1;
      end
      default: ;
    endcase
  end

  always_comb begin
    head_v = fire && !mismatch;
    head_e = a_e;
    head_d = a_e ? '0 : res;
  end

  always_comb begin
    err_d = err_q | (fire && mismatch);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      add_stream_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (stg_adv[0]),
        .in_v  (head_v),
        .in_e  (head_e),
        .in_d  (head_d),
        .out_v (stg_v[0]),
        .out_e (stg_e[0]),
        .out_d (stg_d[0])
      );
    end else begin : g_body
      add_stream_stage #(.WIDTH(WIDTH)) u_stage (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (stg_adv[g]),
        .in_v  (stg_v[g-1]),
        .in_e  (stg_e[g-1]),
        .in_d  (stg_d[g-1]),
        .out_v (stg_v[g]),
        .out_e (stg_e[g]),
        .out_d (stg_d[g])
      );
    end
  end

  assign s_v = stg_v[STAGES-1];
  assign s_e = stg_e[STAGES-1];
  assign s_d = stg_d[STAGES-1];
  assign err = err_q;

endmodule

// File: tb/tb_add_stream_pipe.sv
// tb_add_stream_pipe
// Directed bench: four add_stream_pipe instances (WIDTH=8) share one input
// stream; dut 0/1/2 are STAGES=2 with MODE wrap/ssat/usat, dut 3 is
// STAGES=3 wrap. Expected values are hand-computed constants.
module tb_add_stream_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_d, b_d;
  logic       a_e, b_e, a_v, b_v, s_b;

  logic [7:0] sd [4];
  logic       se [4];
  logic       sv [4];
  logic       ab [4];
  logic       bb [4];
  logic       er [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  add_stream_pipe #(.WIDTH(8), .STAGES(2), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(ab[0]),
    .b_d(b_d), .b_e(b_e), .b_v(b_v), .b_b(bb[0]),
    .s_d(sd[0]), .s_e(se[0]), .s_v(sv[0]), .s_b(s_b), .err(er[0]));

  add_stream_pipe #(.WIDTH(8), .STAGES(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(ab[1]),
    .b_d(b_d), .b_e(b_e), .b_v(b_v), .b_b(bb[1]),
    .s_d(sd[1]), .s_e(se[1]), .s_v(sv[1]), .s_b(s_b), .err(er[1]));

  add_stream_pipe #(.WIDTH(8), .STAGES(2), .MODE(2)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(ab[2]),
    .b_d(b_d), .b_e(b_e), .b_v(b_v), .b_b(bb[2]),
    .s_d(sd[2]), .s_e(se[2]), .s_v(sv[2]), .s_b(s_b), .err(er[2]));

  add_stream_pipe #(.WIDTH(8), .STAGES(3), .MODE(0)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .a_d(a_d), .a_e(a_e), .a_v(a_v), .a_b(ab[3]),
    .b_d(b_d), .b_e(b_e), .b_v(b_v), .b_b(bb[3]),
    .s_d(sd[3]), .s_e(se[3]), .s_v(sv[3]), .s_b(s_b), .err(er[3]));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_d = 8'd200; b_d = 8'd100; a_e = 1'b0; b_e = 1'b0;
    a_v = 1'b1;   b_v = 1'b1;   s_b = 1'b0;
    cyc();
    cyc();
    check("rst_sv",  sv[0], 0);
    check("rst_sd",  sd[0], 0);
    check("rst_se",  se[0], 0);
    check("rst_err", er[0], 0);
    check("rst_ab",  ab[0], 1);
    check("rst_bb",  bb[0], 1);
    check("rst_ab3", ab[3], 1);

    // First pair fires on the first edge after release.
    rst_n = 1'b1;
    #1;
    check("rel_ab", ab[0], 0);
    check("rel_bb", bb[0], 0);
    cyc();
    a_v = 1'b0; b_v = 1'b0;
    check("lat_sv_early", sv[0], 0);
    cyc();
    check("wrap_sv",  sv[0], 1);
    check("wrap_sd",  sd[0], 44);
    check("ssat_sd",  sd[1], 44);
    check("usat_sd",  sd[2], 255);
    check("s3_early", sv[3], 0);
    cyc();
    check("s3_sv",    sv[3], 1);
    check("s3_sd",    sd[3], 44);
    check("wrap_gone", sv[0], 0);

    // Saturation pairs back to back.
    a_d = 8'd100; b_d = 8'd100; a_v = 1'b1; b_v = 1'b1;
    cyc();
    a_d = 8'h9C; b_d = 8'h9C;
    cyc();
    a_v = 1'b0; b_v = 1'b0;
    check("pos_wrap_sd", sd[0], 200);
    check("pos_ssat_sd", sd[1], 127);
    check("pos_usat_sd", sd[2], 200);
    cyc();
    check("neg_wrap_sd", sd[0], 56);
    check("neg_ssat_sd", sd[1], 8'h80);
    check("neg_usat_sd", sd[2], 255);
    check("neg_sv",      sv[1], 1);
    cyc();
    cyc();

    // 16 back-to-back pairs: a=k, b=2k, so sum = 3k.
    for (int k = 0; k < 20; k++) begin
      if (k < 16) begin
        a_v = 1'b1; b_v = 1'b1;
        a_d = 8'(k); b_d = 8'(2 * k);
      end else begin
        a_v = 1'b0; b_v = 1'b0;
      end
      cyc();
      check($sformatf("b2b_sv%0d", k), sv[0], (k >= 1 && k <= 16) ? 1 : 0);
      if (k >= 1 && k <= 16) check($sformatf("b2b_sd%0d", k), sd[0], 3 * (k - 1));
    end

    // STAGES=3 fill under s_b=1: three accepted, then blocked.
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    s_b = 1'b1;
    a_v = 1'b1; b_v = 1'b1; a_d = 8'd10; b_d = 8'd1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check($sformatf("full_ab%0d", c), ab[3], (c >= 3) ? 1 : 0);
      check($sformatf("full_bb%0d", c), bb[3], (c >= 3) ? 1 : 0);
      if (c >= 3) begin
        check($sformatf("hold_sv%0d", c), sv[3], 1);
        check($sformatf("hold_sd%0d", c), sd[3], 11);
      end
      cyc();
      if (c < 3) a_d = a_d + 8'd1;
    end
    // Releasing s_b drains the full pipe and fires in the same cycle.
    s_b = 1'b0;
    #1;
    check("simul_ab", ab[3], 0);
    for (int k = 0; k < 4; k++) begin
      cyc();
      if (k == 0) a_d = 8'd14;
      if (k == 1) begin
        a_v = 1'b0; b_v = 1'b0;
      end
      check($sformatf("drain_sv%0d", k), sv[3], 1);
      check($sformatf("drain_sd%0d", k), sd[3], 12 + k);
    end
    cyc();
    check("drain_end", sv[3], 0);
    cyc();
    cyc();

    // EOS pair, then a mismatch.
    a_e = 1'b1; b_e = 1'b1; a_d = 8'd7; b_d = 8'd9; a_v = 1'b1; b_v = 1'b1;
    #1;
    check("eos_ab", ab[0], 0);
    cyc();
    a_v = 1'b0; b_v = 1'b0; a_e = 1'b0; b_e = 1'b0;
    cyc();
    check("eos_sv",  sv[0], 1);
    check("eos_se",  se[0], 1);
    check("eos_sd",  sd[0], 0);
    check("eos_err", er[0], 0);
    a_e = 1'b1; b_e = 1'b0; b_d = 8'd5; a_v = 1'b1; b_v = 1'b1;
    #1;
    check("mm_ab", ab[0], 0);
    check("mm_bb", bb[0], 0);
    cyc();
    a_v = 1'b0; b_v = 1'b0; a_e = 1'b0;
    check("mm_err",  er[0], 1);
    check("mm_err1", er[1], 1);
    cyc();
    check("mm_nosv", sv[0], 0);
    check("mm_sticky1", er[0], 1);
    cyc();
    cyc();
    check("mm_sticky2", er[0], 1);

    // Async reset with two tokens in flight.
    a_d = 8'd1; b_d = 8'd1; a_v = 1'b1; b_v = 1'b1;
    cyc();
    a_d = 8'd2; b_d = 8'd2;
    cyc();
    a_v = 1'b0; b_v = 1'b0;
    check("inflight_sv", sv[0], 1);
    check("inflight_sd", sd[0], 2);
    rst_n = 1'b0;
    #1;
    check("arst_sv",  sv[0], 0);
    check("arst_sd",  sd[0], 0);
    check("arst_err", er[0], 0);
    cyc();
    rst_n = 1'b1;
    a_d = 8'd3; b_d = 8'd4; a_v = 1'b1; b_v = 1'b1;
    cyc();
    a_v = 1'b0; b_v = 1'b0;
    check("post_early", sv[0], 0);
    cyc();
    check("post_sv", sv[0], 1);
    check("post_sd", sd[0], 7);
    cyc();
    check("post_alone", sv[0], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/add_stream_pipe.md
# add_stream_pipe

Parametrised streaming adder that replaces the single-bit, single-state combinational add datapath with a W-bit, flow-controlled, pipelined operator. It consumes two input streams `a` and `b`, pairs their head tokens, and emits one sum token per pair on stream `s`. It has a selectable overflow mode, end-of-stream pairing and a sticky EOS-mismatch flag. It sits between stream FIFOs in the generated operator graph, in place of the plain add datapath wherever width > 1 or back-pressure is present.

## Interface
- WIDTH, 16, data width of a, b and s (1..64)
- STAGES, 2, pipeline register stages from accept to output (1..4)
- MODE, 0, overflow mode: 0 wrap, 1 signed saturate, 2 unsigned saturate
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- a_d  in  WIDTH  operand a data
- a_e  in  1  a head token is end-of-stream (data ignored)
- a_v  in  1  a head token valid
- a_b  out  1  back-pressure to a; 1 = token not taken this cycle
- b_d, b_e, b_v  in  WIDTH/1/1  operand b, same meaning as a
- b_b  out  1  back-pressure to b
- s_d  out  WIDTH  sum data
- s_e  out  1  output token is end-of-stream
- s_v  out  1  output token valid
- s_b  in  1  back-pressure from consumer; 1 = hold output
- err  out  1  sticky EOS-mismatch flag

## Operation
- Fire condition: a_v && b_v && stage-1 can advance. On fire both heads are consumed in the same cycle. a_b = b_b = !fire.
- Data pair (a_e=0, b_e=0): sum computed in stage 1 at WIDTH+1 bits.
  - MODE 0: low WIDTH bits.
  - MODE 1: signed; on overflow clamp to 2^(WIDTH-1)-1 or -2^(WIDTH-1).
  - MODE 2: unsigned; on carry-out clamp to 2^WIDTH-1.
- EOS pair (a_e=1, b_e=1): emits one token with s_e=1, s_d=0.
- Mismatch (exactly one of a_e/b_e set): both heads consumed, nothing emitted, err set. err clears only on reset.
- Stages carry {valid, e, d}. Stage i advances when stage i empty or stage i+1 advances. The last stage advances when s_v=0 or s_b=0. Bubbles collapse, and there is no throughput loss under partial stall.
- No token is dropped or duplicated under any s_b pattern.

## Timing
- Reset (async assert): all stage valids 0, s_d=0, s_e=0, s_v=0, err=0. a_b and b_b read 1 while reset is asserted and 0 from the first cycle after release (pipeline empty).
- Latency: a token fired at edge N is presented on s_* after edge N+STAGES-1, i.e. s_v is visible in the cycle after STAGES edges including the fire edge.
- Throughput: 1 token/cycle while s_b=0.
- Full: all STAGES valid and s_b=1 → fire blocked and a_b=b_b=1 in the same cycle. The combinational path s_b → a_b/b_b is permitted.
- Simultaneous: s_b falls in the same cycle a pair is presented to a full pipe → output drains and the pair fires in that same cycle.
- Reset mid-stream: all in-flight tokens are discarded and err cleared. No partial token appears after release.
- s_d/s_e hold stable while s_v=1 and s_b=1.

## Structure
- Shared package: MODE_WRAP=0, MODE_SSAT=1, MODE_USAT=2 constants and stage-record field widths, shared with other generated arithmetic operators.
- One sub-module, add_stream_stage: a single valid-tagged register with advance logic, instantiated STAGES times. The top level holds pairing, EOS/err logic and saturation.

## Test plan
- WIDTH=8, MODE 0, s_b=0: a=200, b=100 → s_d=44 after STAGES edges. 16 back-to-back pairs → 16 consecutive s_v cycles.
- WIDTH=8, MODE 1: 100+100 → 127. (-100)+(-100) → -128 (0x80). MODE 2: 200+100 → 255.
- STAGES=3: hold s_b=1 while 5 pairs are offered → exactly 3 accepted, then a_b=b_b=1. Release s_b → outputs appear in order with no loss, and the remaining 2 fire.
- Random a_v/b_v/s_b at 50% over 10k pairs → output equals the reference model sequence exactly, with no duplicates.
- a_e=b_e=1 → one s_e=1 token with s_d=0, err=0. Then a_e=1 with b data=5 → no output, both consumed, err=1 and stays 1 until reset.
- Assert reset with 2 tokens in flight → s_v=0 immediately (async). After release, the first new pair emerges alone with correct latency.
